// File: rtl/btb_update_pkg.sv
// Shared definitions for the BTB write-side engine: way layout,
// predictor state encodings and the allocation state for new entries.
package btb_update_pkg;

  localparam int TAG_W    = 27;
  localparam int IDX_W    = 3;
  localparam int NUM_SETS = 8;
  localparam int WAY_W    = 64;
  localparam int SET_W    = 2 * WAY_W;

  // Two-bit saturating predictor states
  typedef enum logic [1:0] {
    PRED_STRONG_NT = 2'b00,
    PRED_WEAK_NT   = 2'b01,
    PRED_WEAK_T    = 2'b10,
    PRED_STRONG_T  = 2'b11
  } pred_state_e;

  // A freshly allocated entry starts out weakly taken
  localparam logic [1:0] BTB_INIT_STATE = PRED_WEAK_T;

  // One BTB way, most significant field first: bit 63 is valid, [1:0] is state
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic [1:0]       rsvd;
    logic [1:0]       state;
  } btb_way_t;

endpackage

// File: rtl/btb_set_update.sv
// Combinational read-modify-write of one 2-way BTB set: hit detection,
// victim choice, predictor step and the new LRU bit for that set.
module btb_set_update
  import btb_update_pkg::*;
#(
  parameter logic [1:0] INIT_STATE_P = BTB_INIT_STATE
) (
  input  logic [SET_W-1:0] set_in,
  input  logic             lru_in,
  input  logic [TAG_W-1:0] tag,
  input  logic [31:0]      target,
  input  logic             taken,
  output logic [SET_W-1:0] set_out,
  output logic             lru_out,
  output logic             do_write,
  output logic             hit,
  output logic             alloc,
  output logic             evict
);

  btb_way_t   way0;
  btb_way_t   way1;
  btb_way_t   src_way;
  btb_way_t   new_way;
  logic       hit0;
  logic       hit1;
  logic       victim;
  logic       sel_way;
  logic [1:0] cur_state;
  logic [1:0] stepped_state;

  assign way0 = set_in[WAY_W-1:0];
  assign way1 = set_in[SET_W-1:WAY_W];

  // Tag match (way0 wins a double match) and replacement way selection
  always_comb begin
    hit0 = way0.valid && (way0.tag == tag);
    hit1 = way1.valid && (way1.tag == tag) && !hit0;
    hit  = hit0 || hit1;
    if (!way0.valid) begin
      victim = 1'b0;
    end else if (!way1.valid) begin
      victim = 1'b1;
    end else begin
      victim = lru_in;
    end
    sel_way   = hit ? hit1 : victim;
    src_way   = hit1 ? way1 : way0;
    cur_state = src_way.state;
  end

  dynamic_branch_predictor u_pred (
    .state      (cur_state),
    .taken      (taken),
    .next_state (stepped_state)
  );

  // Build the rewritten way and splice it into the set
  always_comb begin
    alloc    = !hit && taken;
    evict    = alloc && (victim ? way1.valid : way0.valid);
    do_write = hit || taken;
    lru_out  = ~sel_way;

    new_way       = '0;
    new_way.valid = 1'b1;
    new_way.tag   = tag;
    if (hit) begin
      new_way.target = taken ? target : src_way.target;
      new_way.state  = stepped_state;
    end else begin
      new_way.target = target;
      new_way.state  = INIT_STATE_P;
    end

    set_out = set_in;
    if (sel_way) begin
      set_out[SET_W-1:WAY_W] = new_way;
    end else begin
      set_out[WAY_W-1:0] = new_way;
    end
  end

endmodule

// File: rtl/dynamic_branch_predictor.sv
// Two-bit saturating counter step shared by the branch predictors.
module dynamic_branch_predictor
  import btb_update_pkg::*;
(
  input  logic [1:0] state,
  input  logic       taken,
  output logic [1:0] next_state
);

  // Move one step toward the resolved direction, holding at either end
  always_comb begin
    next_state = state;
    if (taken) begin
      if (state != PRED_STRONG_T) next_state = state + 2'd1;
    end else begin
      if (state != PRED_STRONG_NT) next_state = state - 2'd1;
    end
  end

endmodule

// File: rtl/btb_update.sv
// BTB write-side engine: two-stage pipeline that turns resolved-branch
// reports into set and LRU writes, with same-set bypass from stage B.
// Define BTB_STATS_EN to build the saturating hit/alloc/evict counters.
module btb_update
  import btb_update_pkg::*;
#(
  parameter logic [1:0] INIT_STATE = BTB_INIT_STATE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                update,
  input  logic [31:0]         update_pc,
  input  logic [31:0]         update_target,
  input  logic                actual_taken,
  output logic [IDX_W-1:0]    update_index,
  input  logic [SET_W-1:0]    update_set,
  input  logic [NUM_SETS-1:0] LRU,
  output logic [IDX_W-1:0]    write_index,
  output logic [SET_W-1:0]    write_set,
  output logic                write_en,
  output logic                LRU_modify,
  output logic [NUM_SETS-1:0] LRU_updated,
  output logic [15:0]         stat_hits,
  output logic [15:0]         stat_allocs,
  output logic [15:0]         stat_evicts
);

  logic                a_valid_q,  a_valid_d;
  logic [TAG_W-1:0]    a_tag_q,    a_tag_d;
  logic [IDX_W-1:0]    a_idx_q,    a_idx_d;
  logic [31:0]         a_target_q, a_target_d;
  logic                a_taken_q,  a_taken_d;

  logic                write_en_q,    write_en_d;
  logic [IDX_W-1:0]    write_index_q, write_index_d;
  logic [SET_W-1:0]    write_set_q,   write_set_d;
  logic                lru_modify_q,  lru_modify_d;
  logic [NUM_SETS-1:0] lru_updated_q, lru_updated_d;

  logic [SET_W-1:0]    eff_set;
  logic [NUM_SETS-1:0] eff_lru;
  logic [SET_W-1:0]    new_set;
  logic                new_lru_bit;
  logic                do_write;
  logic                hit;
  logic                alloc;
  logic                evict;
  logic                commit;
  logic                unused_pc_bits;

  assign unused_pc_bits = ^update_pc[1:0];

  // Stage A request capture; update=0 leaves a bubble
  always_comb begin
    a_valid_d  = update;
    a_tag_d    = a_tag_q;
    a_idx_d    = a_idx_q;
    a_target_d = a_target_q;
    a_taken_d  = a_taken_q;
    if (update) begin
      a_tag_d    = update_pc[31:5];
      a_idx_d    = update_pc[4:2];
      a_target_d = update_target;
      a_taken_d  = actual_taken;
    end
  end

  // Stage A registers, cleared by reset so in-flight work is dropped
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_valid_q  <= 1'b0;
      a_tag_q    <= '0;
      a_idx_q    <= '0;
      a_target_q <= '0;
      a_taken_q  <= 1'b0;
    end else begin
      a_valid_q  <= a_valid_d;
      a_tag_q    <= a_tag_d;
      a_idx_q    <= a_idx_d;
      a_target_q <= a_target_d;
      a_taken_q  <= a_taken_d;
    end
  end

  // Stage B's write only lands at the end of this cycle, so forward it
  always_comb begin
    update_index = a_idx_q;
    eff_set = (write_en_q && (write_index_q == a_idx_q)) ? write_set_q : update_set;
    eff_lru = lru_modify_q ? lru_updated_q : LRU;
  end

  btb_set_update #(
    .INIT_STATE_P (INIT_STATE)
  ) u_set_update (
    .set_in   (eff_set),
    .lru_in   (eff_lru[a_idx_q]),
    .tag      (a_tag_q),
    .target   (a_target_q),
    .taken    (a_taken_q),
    .set_out  (new_set),
    .lru_out  (new_lru_bit),
    .do_write (do_write),
    .hit      (hit),
    .alloc    (alloc),
    .evict    (evict)
  );

  // Stage B next values; data outputs hold between commits
  always_comb begin
    commit        = a_valid_q && do_write;
    write_en_d    = commit;
    lru_modify_d  = commit;
    write_index_d = write_index_q;
    write_set_d   = write_set_q;
    lru_updated_d = lru_updated_q;
    if (commit) begin
      write_index_d          = a_idx_q;
      write_set_d            = new_set;
      lru_updated_d          = eff_lru;
      lru_updated_d[a_idx_q] = new_lru_bit;
    end
  end

  // Stage B registered outputs toward btb_file and lru_reg
  always_ff @(posedge clk) begin
    if (!rst) begin
      write_en_q    <= 1'b0;
      write_index_q <= '0;
      write_set_q   <= '0;
      lru_modify_q  <= 1'b0;
      lru_updated_q <= '0;
    end else begin
      write_en_q    <= write_en_d;
      write_index_q <= write_index_d;
      write_set_q   <= write_set_d;
      lru_modify_q  <= lru_modify_d;
      lru_updated_q <= lru_updated_d;
    end
  end

  assign write_en    = write_en_q;
  assign write_index = write_index_q;
  assign write_set   = write_set_q;
  assign LRU_modify  = lru_modify_q;
  assign LRU_updated = lru_updated_q;

`ifdef BTB_STATS_EN
  logic [15:0] stat_hits_q,   stat_hits_d;
  logic [15:0] stat_allocs_q, stat_allocs_d;
  logic [15:0] stat_evicts_q, stat_evicts_d;

  // Saturating event counters advanced alongside the stage B commit
  always_comb begin
    stat_hits_d   = stat_hits_q;
    stat_allocs_d = stat_allocs_q;
    stat_evicts_d = stat_evicts_q;
    if (a_valid_q && hit && (stat_hits_q != 16'hFFFF)) stat_hits_d = stat_hits_q + 16'd1;
    if (a_valid_q && alloc && (stat_allocs_q != 16'hFFFF)) stat_allocs_d = stat_allocs_q + 16'd1;
    if (a_valid_q && evict && (stat_evicts_q != 16'hFFFF)) stat_evicts_d = stat_evicts_q + 16'd1;
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_hits_q   <= '0;
      stat_allocs_q <= '0;
      stat_evicts_q <= '0;
    end else begin
      stat_hits_q   <= stat_hits_d;
      stat_allocs_q <= stat_allocs_d;
      stat_evicts_q <= stat_evicts_d;
    end
  end

  assign stat_hits   = stat_hits_q;
  assign stat_allocs = stat_allocs_q;
  assign stat_evicts = stat_evicts_q;
`else
  logic unused_stats;
  assign unused_stats = hit ^ alloc ^ evict;
  assign stat_hits    = '0;
  assign stat_allocs  = '0;
  assign stat_evicts  = '0;
`endif

endmodule

// File: tb/tb_btb_update.sv
// Bench for btb_update: models btb_file/lru_reg around the DUT and checks
// every stage-B output against an entry-level reference model of the BTB.
module tb_btb_update;

  logic         clk = 1'b0;
  logic         rst;
  logic         update;
  logic [31:0]  update_pc;
  logic [31:0]  update_target;
  logic         actual_taken;
  logic [2:0]   update_index;
  logic [127:0] update_set;
  logic [7:0]   LRU;
  logic [2:0]   write_index;
  logic [127:0] write_set;
  logic         write_en;
  logic         LRU_modify;
  logic [7:0]   LRU_updated;
  logic [15:0]  stat_hits;
  logic [15:0]  stat_allocs;
  logic [15:0]  stat_evicts;

  always #5 clk = ~clk;

  btb_update dut (
    .clk           (clk),
    .rst           (rst),
    .update        (update),
    .update_pc     (update_pc),
    .update_target (update_target),
    .actual_taken  (actual_taken),
    .update_index  (update_index),
    .update_set    (update_set),
    .LRU           (LRU),
    .write_index   (write_index),
    .write_set     (write_set),
    .write_en      (write_en),
    .LRU_modify    (LRU_modify),
    .LRU_updated   (LRU_updated),
    .stat_hits     (stat_hits),
    .stat_allocs   (stat_allocs),
    .stat_evicts   (stat_evicts)
  );

  // Storage the DUT reads and writes: btb_file sets and the lru_reg vector
  logic [127:0] env_mem [8] = '{default: '0};
  logic [7:0]   env_lru = '0;

  assign update_set = env_mem[update_index];
  assign LRU        = env_lru;

  always @(posedge clk) begin
    if (write_en) env_mem[write_index] <= write_set;
    if (LRU_modify) env_lru <= LRU_updated;
  end

  // Reference model: BTB as entries with integer predictor states
  typedef struct {
    bit        valid;
    bit [26:0] tag;
    bit [31:0] target;
    int        state;
  } entry_t;

  typedef struct {
    bit         wen;
    bit [2:0]   idx;
    bit [127:0] set;
    bit [7:0]   lru;
    int         hits;
    int         allocs;
    int         evicts;
  } exp_t;

  entry_t m_way [8][2];
  bit     m_lru [8];
  int     m_hits, m_allocs, m_evicts;
  entry_t save_way [8][2];
  bit     save_lru [8];
  exp_t   exp_prev;
  int     checks = 0;
  int     passes = 0;

  function automatic int sat16(input int v);
    return (v < 65535) ? v + 1 : v;
  endfunction

  function automatic bit [127:0] pack_set(input int idx);
    bit [127:0] s;
    s = '0;
    for (int w = 0; w < 2; w++)
      s[w*64 +: 64] = {m_way[idx][w].valid, m_way[idx][w].tag, m_way[idx][w].target,
                       2'b00, 2'(m_way[idx][w].state)};
    return s;
  endfunction

  function automatic bit [7:0] pack_lru();
    bit [7:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[i] = m_lru[i];
    return v;
  endfunction

  function automatic exp_t bubble();
    exp_t e;
    e.wen    = 1'b0;
    e.idx    = '0;
    e.set    = '0;
    e.lru    = '0;
    e.hits   = m_hits;
    e.allocs = m_allocs;
    e.evicts = m_evicts;
    return e;
  endfunction

  task automatic model_update(input bit [31:0] pc, input bit [31:0] tgt, input bit tk,
                              output exp_t e);
    int        idx;
    bit [26:0] ptag;
    int        hw;
    int        victim;
    idx  = int'(pc[4:2]);
    ptag = pc[31:5];
    hw   = -1;
    e    = bubble();
    for (int w = 0; w < 2; w++)
      if (hw < 0 && m_way[idx][w].valid && m_way[idx][w].tag == ptag) hw = w;
    if (hw >= 0) begin
      if (tk) begin
        m_way[idx][hw].state  = (m_way[idx][hw].state == 3) ? 3 : m_way[idx][hw].state + 1;
        m_way[idx][hw].target = tgt;
      end else begin
        m_way[idx][hw].state = (m_way[idx][hw].state == 0) ? 0 : m_way[idx][hw].state - 1;
      end
      m_lru[idx] = (hw == 0);
      m_hits     = sat16(m_hits);
      e.wen      = 1'b1;
    end else if (tk) begin
      if (!m_way[idx][0].valid) victim = 0;
      else if (!m_way[idx][1].valid) victim = 1;
      else victim = int'(m_lru[idx]);
      if (m_way[idx][victim].valid) m_evicts = sat16(m_evicts);
      m_way[idx][victim].valid  = 1'b1;
      m_way[idx][victim].tag    = ptag;
      m_way[idx][victim].target = tgt;
      m_way[idx][victim].state  = 2;
      m_lru[idx] = (victim == 0);
      m_allocs   = sat16(m_allocs);
      e.wen      = 1'b1;
    end
    e.idx    = 3'(idx);
    e.set    = pack_set(idx);
    e.lru    = pack_lru();
    e.hits   = m_hits;
    e.allocs = m_allocs;
    e.evicts = m_evicts;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks = checks + 1;
    assert (obs === exp) passes = passes + 1;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Compare the stage-B outputs against the request issued one step earlier
  task automatic checkPipe();
    checkOutput("write_en", 128'(write_en), 128'(exp_prev.wen));
    checkOutput("LRU_modify", 128'(LRU_modify), 128'(exp_prev.wen));
    if (exp_prev.wen) begin
      checkOutput("write_index", 128'(write_index), 128'(exp_prev.idx));
      checkOutput("write_set", write_set, exp_prev.set);
      checkOutput("LRU_updated", 128'(LRU_updated), 128'(exp_prev.lru));
    end
`ifdef BTB_STATS_EN
    checkOutput("stat_hits", 128'(stat_hits), 128'(exp_prev.hits));
    checkOutput("stat_allocs", 128'(stat_allocs), 128'(exp_prev.allocs));
    checkOutput("stat_evicts", 128'(stat_evicts), 128'(exp_prev.evicts));
`else
    checkOutput("stat_hits", 128'(stat_hits), 128'(0));
    checkOutput("stat_allocs", 128'(stat_allocs), 128'(0));
    checkOutput("stat_evicts", 128'(stat_evicts), 128'(0));
`endif
  endtask

  // Drive one cycle of inputs, step past the edge and check the pipeline
  task automatic applyStimulus(input bit u, input bit [31:0] pc, input bit [31:0] tgt,
                               input bit tk);
    exp_t e;
    update        = u;
    update_pc     = pc;
    update_target = tgt;
    actual_taken  = tk;
    if (u && rst) model_update(pc, tgt, tk, e);
    else e = bubble();
    @(posedge clk);
    #1;
    checkPipe();
    exp_prev = e;
  endtask

  // Directed scenarios followed by randomized traffic
  initial begin
    int exp_ev;
    rst           = 1'b0;
    update        = 1'b0;
    update_pc     = '0;
    update_target = '0;
    actual_taken  = 1'b0;
    m_hits        = 0;
    m_allocs      = 0;
    m_evicts      = 0;
    exp_prev      = bubble();

    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("rst_write_index", 128'(write_index), 128'(0));
    checkOutput("rst_write_set", write_set, 128'(0));
    checkOutput("rst_LRU_updated", 128'(LRU_updated), 128'(0));
    rst = 1'b1;

    $display("[TB] allocate into empty set 0");
    applyStimulus(1, 32'h0000_0040, 32'h100, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("alloc_way0", 128'(write_set[63:0]), 128'({1'b1, 27'h2, 32'h100, 4'b0010}));
    checkOutput("alloc_lru0", 128'(LRU_updated[0]), 128'(1));
    checkOutput("alloc_index", 128'(write_index), 128'(0));

    $display("[TB] back-to-back taken updates through the bypass");
    applyStimulus(1, 32'h0000_0044, 32'h300, 1);
    applyStimulus(1, 32'h0000_0044, 32'h300, 1);
    checkOutput("b2b_state1", 128'(write_set[1:0]), 128'(2'b10));
    applyStimulus(1, 32'h0000_0044, 32'h300, 1);
    checkOutput("b2b_state2", 128'(write_set[1:0]), 128'(2'b11));
    applyStimulus(0, 0, 0, 0);
    checkOutput("b2b_state3", 128'(write_set[1:0]), 128'(2'b11));

    $display("[TB] fill set 0 then evict the LRU way");
    applyStimulus(1, 32'h0000_0060, 32'h600, 1);
    applyStimulus(1, 32'h0000_00A0, 32'hA00, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("evict_way0_tag", 128'(write_set[62:36]), 128'(27'h5));
    checkOutput("evict_way1_tag", 128'(write_set[126:100]), 128'(27'h3));
    checkOutput("evict_lru0", 128'(LRU_updated[0]), 128'(1));
`ifdef BTB_STATS_EN
    exp_ev = 1;
`else
    exp_ev = 0;
`endif
    checkOutput("evict_count", 128'(stat_evicts), 128'(exp_ev));

    $display("[TB] not-taken miss writes nothing");
    applyStimulus(1, 32'h0000_1000, 32'h50, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0);
      checkOutput("nt_miss_wen", 128'(write_en), 128'(0));
      checkOutput("nt_miss_lru", 128'(LRU_modify), 128'(0));
    end

    $display("[TB] not-taken hit on strong taken entry");
    applyStimulus(1, 32'h0000_0044, 32'h200, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("nt_hit_state", 128'(write_set[1:0]), 128'(2'b10));
    checkOutput("nt_hit_target", 128'(write_set[35:4]), 128'(32'h300));

    $display("[TB] reset while an update is in flight");
    save_way = m_way;
    save_lru = m_lru;
    applyStimulus(1, 32'h0000_0048, 32'h400, 1);
    m_way    = save_way;
    m_lru    = save_lru;
    m_hits   = 0;
    m_allocs = 0;
    m_evicts = 0;
    exp_prev = bubble();
    rst      = 1'b0;
    applyStimulus(1, 32'h0000_004C, 32'h500, 1);
    checkOutput("midrst_write_index", 128'(write_index), 128'(0));
    checkOutput("midrst_write_set", write_set, 128'(0));
    checkOutput("midrst_LRU_updated", 128'(LRU_updated), 128'(0));
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      bit [31:0] pc;
      bit [26:0] rtag;
      rtag = 27'($urandom_range(0, 5));
      if ($urandom_range(0, 19) == 0) rtag = 27'($urandom);
      pc = {rtag, 3'($urandom_range(0, 7)), 2'($urandom)};
      applyStimulus($urandom_range(0, 9) < 8, pc, $urandom, $urandom_range(0, 9) < 7);
    end
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/btb_update.md
Name: btb_update

Overview:
- Write-side engine of the branch target buffer (BTB); complements the prediction-read path.
- Takes resolved-branch reports from EX and performs a read-modify-write of the matching 2-way set in btb_file.
- Maintains each entry's 2-bit predictor and the per-set LRU bit.
- 2-stage pipeline, accepts one update per cycle, with same-set bypass.

Parameters:
- TAG_W, 27, tag width (pc[31:5]).
- IDX_W, 3, set index width (pc[4:2]); 8 sets.
- INIT_STATE, 2'b10, predictor state given to a newly allocated entry (weak taken).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- update  in  1  resolved-branch report valid this cycle
- update_pc  in  32  PC of the resolved branch
- update_target  in  32  resolved target address
- actual_taken  in  1  resolved branch direction
- update_index  out  3  set index driven to btb_file for the combinational read
- update_set  in  128  current set contents returned by btb_file
- LRU  in  8  current LRU vector from lru_reg
- write_index  out  3  set index being written
- write_set  out  128  new set contents
- write_en  out  1  set write strobe
- LRU_modify  out  1  LRU vector write strobe
- LRU_updated  out  8  new LRU vector
- stat_hits  out  16  update hits (see Optional Feature)
- stat_allocs  out  16  allocations (see Optional Feature)
- stat_evicts  out  16  valid-entry evictions (see Optional Feature)

Behaviour:
- Set layout:
  - way0 = [63:0], way1 = [127:64].
  - Each way: [63] valid, [62:36] tag, [35:4] target, [3:2] reserved (written 0), [1:0] predictor state.
- LRU bit semantics: LRU[i]=1 means way1 of set i is least recently used; LRU[i]=0 means way0.
- Predictor states: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
  - Taken: +1, saturating at 11.
  - Not taken: -1, saturating at 00.
- Stage A (registered request):
  - On the clk edge with update=1, capture pc, target and taken, and set a_valid.
  - update_index = a_pc[4:2] continuously.
- Stage A compute, combinational, using update_set/LRU or the bypass:
  - Hit = a valid way whose tag equals a_pc[31:5].
  - If both ways match (illegal), way0 wins.
  - Hit: advance that way's state. If taken, overwrite its target with a_target. The new LRU bit points to the other way.
  - Miss, taken: allocate the first invalid way (way0 before way1), else the LRU way. Write valid=1, tag, target, state=INIT_STATE. LRU bit points to the other way. Count an eviction if the victim was valid.
  - Miss, not taken: no set write and no LRU write.
- Stage B (registered outputs):
  - write_en, write_index, write_set, LRU_modify and LRU_updated are registered from stage A.
  - Latency: update asserted in cycle N gives write_en/LRU_modify in cycle N+2, pulsed for 1 cycle.
- Bypass:
  - Stage B's write lands at the end of cycle N+2, so a stage-A request in that cycle reads stale data.
  - If b_write_en and write_index==a index, stage A uses write_set in place of update_set.
  - If LRU_modify, stage A uses LRU_updated in place of LRU.
  - Back-to-back updates to the same PC must therefore saturate correctly.
- update=0 inserts a bubble: a_valid=0 and nothing is written.
- Reset (rst=0 at a clk edge):
  - a_valid=0, write_en=0, LRU_modify=0.
  - write_index=0, write_set=0, LRU_updated=0, counters=0.
  - In-flight requests are discarded even mid-pipeline.
  - Reset dominates update in the same cycle.

Optional Feature:
- BTB_STATS_EN defined:
  - stat_hits, stat_allocs and stat_evicts increment at stage B commit.
  - Each counter saturates at 16'hFFFF.
- BTB_STATS_EN undefined: the three counters are constant 0 and no counter flops are synthesised.

Decomposition:
- Shared package/defines: BTB way field offsets, way width (64), predictor state encodings, INIT_STATE.
- One sub-module, btb_set_update: combinational hit/victim/predictor/LRU computation taking set, LRU bit, tag, target and taken.
  - This is the same kind of saturating state logic as dynamic_branch_predictor; reuse that module for the state step.

Test Plan:
- Empty BTB; update pc=0x0000_0040, target=0x100, taken:
  - Cycle N+2: write_en=1, write_index=0, way0 = valid, tag 0x2, target 0x100, state 10.
  - LRU_modify=1, LRU_updated[0]=1.
- Same pc updated taken in 3 consecutive cycles (bypass path):
  - States written are 10, 11, 11, with no stale read between commits.
- Set 0 holds two valid ways with LRU[0]=0; taken miss with tag 0x5:
  - way0 replaced, LRU_updated[0]=1, stat_evicts=1 (BTB_STATS_EN).
- Miss with actual_taken=0:
  - write_en and LRU_modify stay 0 for the next 3 cycles.
- Hit on state 11, not taken, target 0x200:
  - State becomes 10; target unchanged.
- rst=0 during cycle N+1 of a pending update:
  - No write_en in N+2; all outputs 0.
